// File: rtl/i2s_sched_pkg.sv
// Shared types and helpers for the I2S stream scheduler: FSM states, route
// modes and a counter-width helper.
package i2s_sched_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_C1    = 2'd0,
    MODE_C2    = 2'd1,
    MODE_XOR   = 2'd2,
    MODE_SPLIT = 2'd3
  } route_mode_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/i2s_stream_scheduler_ws_tracker.sv
// Word-select tracker: ws pipeline, edge pulses, per-half-word bit counter,
// measured half-word length and its comparison against a stored reference.
module i2s_ws_tracker
  import i2s_sched_pkg::*;
#(
  parameter int MAX_BITS = 32,
  parameter int MIN_BITS = 8
)(
  input  logic                             i_sck,
  input  logic                             i_rst_n,
  input  logic                             i_ws,
  input  logic                             i_ref_load,
  output logic                             o_wsd,
  output logic                             o_wsp,
  output logic                             o_frame_start,
  output logic [cnt_width(MAX_BITS)-1:0]   o_bit_cnt,
  output logic                             o_len_eq,
  output logic                             o_len_ok,
  output logic                             o_sat
);

  localparam int CW = cnt_width(MAX_BITS);
  localparam int LW = cnt_width(MAX_BITS + 1);

  logic          r_ws1;
  logic          r_ws2;
  logic [CW-1:0] r_bit_cnt;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_ref;
  logic          w_edge_next;

  // Edge seen one cycle early so bit_cnt reads 0 in the same cycle wsp is high.
  assign w_edge_next = i_ws ^ r_ws1;

  always_ff @(posedge i_sck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ws1     <= 1'b0;
      r_ws2     <= 1'b0;
      r_bit_cnt <= '0;
      r_len     <= '0;
      r_ref     <= '0;
    end else begin
      r_ws1 <= i_ws;
      r_ws2 <= r_ws1;
      if (w_edge_next) begin
        r_bit_cnt <= '0;
        r_len     <= LW'(r_bit_cnt) + 1'b1;
      end else if (r_bit_cnt != CW'(MAX_BITS)) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (i_ref_load) begin
        r_ref <= r_len;
      end
    end
  end

  assign o_wsd         = r_ws1;
  assign o_wsp         = r_ws1 ^ r_ws2;
  assign o_frame_start = (r_ws1 ^ r_ws2) & ~r_ws1;
  assign o_bit_cnt     = r_bit_cnt;
  assign o_len_eq      = (r_len == r_ref);
  assign o_len_ok      = (r_len >= LW'(MIN_BITS)) && (r_len <= LW'(MAX_BITS));
  assign o_sat         = (r_bit_cnt == CW'(MAX_BITS));

endmodule

// File: rtl/i2s_stream_scheduler.sv
// Frame-level sequencer for the dual-input I2S datapath, clocked by sck.
// Optional frame counter is built only when FRAME_CNT_EN is defined.
module i2s_stream_scheduler
  import i2s_sched_pkg::*;
#(
  parameter int MAX_BITS   = 32,
  parameter int MIN_BITS   = 8,
  parameter int LOCK_WORDS = 4
)(
  input  logic                             i_sck,
  input  logic                             i_rst_n,
  input  logic                             i_ws,
  input  logic                             i_sd_c1,
  input  logic                             i_sd_c2,
  input  logic                             i_cfg_valid,
  input  logic [1:0]                       i_cfg_mode,
  output logic                             o_cfg_ack,
  output logic                             o_sd_out,
  output logic                             o_wsd,
  output logic                             o_wsp,
  output logic [cnt_width(MAX_BITS)-1:0]   o_bit_cnt,
  output logic                             o_frame_start,
  output logic                             o_locked,
  output logic                             o_err,
  output logic [15:0]                      o_frame_cnt
);

  localparam int CW = cnt_width(MAX_BITS);
  localparam int NW = cnt_width(LOCK_WORDS);
  localparam logic [NW-1:0] LOCK_CNT = NW'(LOCK_WORDS);

  logic          w_wsd;
  logic          w_wsp;
  logic          w_frame_start;
  logic [CW-1:0] w_bit_cnt;
  logic          w_len_eq;
  logic          w_len_ok;
  logic          w_sat;
  logic          w_ref_load;
  logic          w_len_good;
  logic          w_in_locked;
  logic          w_err_now;
  logic          w_accept;
  logic          w_route;
  logic [NW-1:0] w_count_next;
  route_mode_t   w_mode_eff;

  state_t        r_state;
  route_mode_t   r_mode;
  logic [NW-1:0] r_count;
  logic          r_d1;
  logic          r_d2;
  logic          r_sd_out;
  logic          r_locked;
  logic          r_err;
  logic          r_cfg_ack;
  logic          r_cfg_done;

  i2s_ws_tracker #(
    .MAX_BITS (MAX_BITS),
    .MIN_BITS (MIN_BITS)
  ) u_tracker (
    .i_sck         (i_sck),
    .i_rst_n       (i_rst_n),
    .i_ws          (i_ws),
    .i_ref_load    (w_ref_load),
    .o_wsd         (w_wsd),
    .o_wsp         (w_wsp),
    .o_frame_start (w_frame_start),
    .o_bit_cnt     (w_bit_cnt),
    .o_len_eq      (w_len_eq),
    .o_len_ok      (w_len_ok),
    .o_sat         (w_sat)
  );

  assign w_in_locked  = (r_state == LOCKED);
  assign w_len_good   = w_len_eq & w_len_ok;
  assign w_err_now    = w_in_locked & (w_wsp ? ~w_len_eq : w_sat);
  // A pending error blocks the accept; the request is taken the edge after.
  assign w_accept     = i_cfg_valid & ~r_cfg_done & ~w_err_now &
                        (~w_in_locked | w_frame_start);
  assign w_mode_eff   = w_accept ? route_mode_t'(i_cfg_mode) : r_mode;
  assign w_ref_load   = (r_state == MEASURE) & w_wsp & ~w_len_good;
  assign w_count_next = ~w_len_good ? NW'(1) :
                        (r_count >= LOCK_CNT) ? r_count : r_count + 1'b1;

  always_comb begin
    w_route = r_d1;
    case (w_mode_eff)
      MODE_C1:    w_route = r_d1;
      MODE_C2:    w_route = r_d2;
      MODE_XOR:   w_route = r_d1 ^ r_d2;
      MODE_SPLIT: w_route = w_wsd ? r_d2 : r_d1;
      default:    w_route = r_d1;
    endcase
  end

  always_ff @(posedge i_sck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= SYNC;
      r_mode     <= MODE_C1;
      r_count    <= '0;
      r_d1       <= 1'b0;
      r_d2       <= 1'b0;
      r_sd_out   <= 1'b0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_cfg_ack  <= 1'b0;
      r_cfg_done <= 1'b0;
    end else begin
      r_d1       <= i_sd_c1;
      r_d2       <= i_sd_c2;
      r_err      <= 1'b0;
      r_cfg_ack  <= w_accept;
      r_cfg_done <= i_cfg_valid & (r_cfg_done | w_accept);
      r_sd_out   <= w_in_locked ? w_route : 1'b0;
      if (w_accept) begin
        r_mode <= route_mode_t'(i_cfg_mode);
      end
      case (r_state)
        SYNC: begin
          if (w_wsp) begin
            r_state <= MEASURE;
            r_count <= '0;
          end
        end
        MEASURE: begin
          if (w_wsp) begin
            r_count <= w_count_next;
            if ((w_count_next >= LOCK_CNT) && w_frame_start) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (w_err_now) begin
            r_state  <= SYNC;
            r_locked <= 1'b0;
            r_err    <= 1'b1;
          end
        end
        default: begin
          r_state  <= SYNC;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge i_sck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_err_now || (r_state == SYNC)) begin
      r_frame_cnt <= '0;
    end else if (w_in_locked && w_frame_start) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`else
  assign o_frame_cnt = 16'd0;
`endif

  assign o_cfg_ack     = r_cfg_ack;
  assign o_sd_out      = r_sd_out;
  assign o_wsd         = w_wsd;
  assign o_wsp         = w_wsp;
  assign o_bit_cnt     = w_bit_cnt;
  assign o_frame_start = w_frame_start;
  assign o_locked      = r_locked;
  assign o_err         = r_err;

endmodule

// File: tb/tb_i2s_stream_scheduler.sv
// Directed bench for i2s_stream_scheduler: lock, routing modes, config
// handshake, length error, saturation, frame counter and async reset.
module tb_i2s_stream_scheduler;

  logic        sck = 1'b0;
  logic        rst_n;
  logic        ws;
  logic        c1;
  logic        c2;
  logic        cfg_valid;
  logic [1:0]  cfg_mode;
  logic        cfg_ack;
  logic        sd_out;
  logic        wsd;
  logic        wsp;
  logic [5:0]  bit_cnt;
  logic        frame_start;
  logic        locked;
  logic        err;
  logic [15:0] frame_cnt;

  int n_vec = 0;
  int n_bad = 0;

`ifdef FRAME_CNT_EN
  localparam int FC_EXP = 5;
`else
  localparam int FC_EXP = 0;
`endif

  i2s_stream_scheduler dut (
    .i_sck         (sck),
    .i_rst_n       (rst_n),
    .i_ws          (ws),
    .i_sd_c1       (c1),
    .i_sd_c2       (c2),
    .i_cfg_valid   (cfg_valid),
    .i_cfg_mode    (cfg_mode),
    .o_cfg_ack     (cfg_ack),
    .o_sd_out      (sd_out),
    .o_wsd         (wsd),
    .o_wsp         (wsp),
    .o_bit_cnt     (bit_cnt),
    .o_frame_start (frame_start),
    .o_locked      (locked),
    .o_err         (err),
    .o_frame_cnt   (frame_cnt)
  );

  always #5 sck = ~sck;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("  ok %s = %0d", tag, got);
    end
  endtask

  task automatic cyc(input logic wsv);
    ws = wsv;
    @(posedge sck);
    @(negedge sck);
  endtask

  task automatic run(input logic wsv, input int n);
    for (int i = 0; i < n; i++) cyc(wsv);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   seen;
    int   err_cnt;
    int   err_at;
    logic exp_sd;

    rst_n = 1'b0; ws = 1'b0; c1 = 1'b0; c2 = 1'b0;
    cfg_valid = 1'b0; cfg_mode = 2'd0;
    @(negedge sck);
    @(negedge sck);
    check_val("rst_sd_out", sd_out, 0);
    check_val("rst_locked", locked, 0);
    check_val("rst_err", err, 0);
    check_val("rst_bit_cnt", bit_cnt, 0);
    check_val("rst_ack", cfg_ack, 0);
    rst_n = 1'b1;

    // lock on 16-bit half-words
    run(0, 3);
    cyc(1);
    check_val("first_wsp", wsp, 1);
    check_val("wsd_right", wsd, 1);
    check_val("bit_cnt_msb", bit_cnt, 0);
    check_val("right_not_fs", frame_start, 0);
    run(1, 15);
    check_val("bit_cnt_lsb", bit_cnt, 15);
    cyc(0);
    check_val("frame_start", frame_start, 1);
    run(0, 15);
    run(1, 16); run(0, 16); run(1, 16);
    check_val("pre_lock", locked, 0);
    cyc(0);
    check_val("lock_at_fs_wait", locked, 0);
    cyc(0);
    check_val("lock_at_fs", locked, 1);

    // mode 0: sd_out follows c1
    exp_sd = c1;
    for (int i = 0; i < 14; i++) begin
      c1 = (i % 2 == 0);
      cyc(0);
      if (i < 6) check_val("route_c1", sd_out, exp_sd);
      exp_sd = c1;
    end

    // mode 3 request mid right word waits for frame_start
    c1 = 1'b0; c2 = 1'b0;
    run(1, 5);
    cfg_mode = 2'd3; cfg_valid = 1'b1; seen = 0;
    for (int i = 0; i < 11; i++) begin
      cyc(1);
      if (cfg_ack) seen++;
    end
    check_val("no_ack_midword", seen, 0);
    c1 = 1'b1; c2 = 1'b0;
    cyc(0);
    check_val("ack_wait_fs", cfg_ack, 0);
    c1 = 1'b0; c2 = 1'b1;
    cyc(0);
    check_val("ack_at_fs", cfg_ack, 1);
    check_val("split_left_msb", sd_out, 1);
    cfg_valid = 1'b0;
    cyc(0);
    check_val("split_left_c1", sd_out, 0);
    run(0, 13);
    c1 = 1'b0; c2 = 1'b1;
    cyc(1);
    c1 = 1'b1; c2 = 1'b0;
    cyc(1);
    check_val("split_right_msb", sd_out, 1);
    cyc(1);
    check_val("split_right_c2", sd_out, 0);

    // mode 2 request, applied from the next left MSB
    cfg_mode = 2'd2; cfg_valid = 1'b1;
    run(1, 13);
    c1 = 1'b1; c2 = 1'b1;
    cyc(0);
    cyc(0);
    check_val("ack_xor", cfg_ack, 1);
    check_val("xor_11", sd_out, 0);
    cfg_valid = 1'b0;
    c1 = 1'b1; c2 = 1'b0;
    cyc(0);
    cyc(0);
    check_val("xor_10", sd_out, 1);
    run(0, 12);

    // shortened right word -> err; cfg collides with err
    run(1, 15);
    cfg_mode = 2'd0; cfg_valid = 1'b1;
    cyc(0);
    check_val("err_not_yet", err, 0);
    cyc(0);
    check_val("len_err", err, 1);
    check_val("unlock_on_err", locked, 0);
    check_val("ack_err_wins", cfg_ack, 0);
    cyc(0);
    check_val("err_one_cycle", err, 0);
    check_val("sd_out_sync", sd_out, 0);
    check_val("ack_after_err", cfg_ack, 1);
    cfg_valid = 1'b0;
    run(0, 13);
    run(1, 16); run(0, 16); run(1, 16); run(0, 16); run(1, 16);
    cyc(0);
    cyc(0);
    check_val("relock", locked, 1);

    // ws stuck: counter saturates, single err
    err_cnt = 0; err_at = 0;
    for (int i = 3; i <= 40; i++) begin
      cyc(0);
      if (err) begin
        err_cnt++;
        err_at = i;
      end
    end
    check_val("sat_err_count", err_cnt, 1);
    check_val("sat_err_cycle", err_at, 34);
    check_val("sat_bit_cnt", bit_cnt, 32);
    check_val("sat_unlocked", locked, 0);
    check_val("sat_sd_out", sd_out, 0);

    // relock and run five locked frames
    run(1, 16); run(0, 16); run(1, 16); run(0, 16); run(1, 16);
    run(0, 16);
    for (int f = 0; f < 5; f++) begin
      run(1, 16);
      run(0, 16);
    end
    check_val("locked_frames", locked, 1);
    check_val("frame_cnt", frame_cnt, FC_EXP);

    // asynchronous reset mid-word
    run(1, 7);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_locked", locked, 0);
    check_val("arst_sd_out", sd_out, 0);
    check_val("arst_bit_cnt", bit_cnt, 0);
    check_val("arst_wsd", wsd, 0);
    check_val("arst_err", err, 0);
    check_val("arst_frame_cnt", frame_cnt, 0);
    @(negedge sck);
    rst_n = 1'b1;

    // unlocked handshake: immediate ack, no repeat while held
    ws = 1'b0;
    cfg_mode = 2'd1; cfg_valid = 1'b1;
    cyc(0);
    check_val("ack_unlocked", cfg_ack, 1);
    cyc(0);
    check_val("ack_held_1", cfg_ack, 0);
    cyc(0);
    check_val("ack_held_2", cfg_ack, 0);
    cfg_valid = 1'b0;
    cyc(0);
    cfg_mode = 2'd2; cfg_valid = 1'b1;
    cyc(0);
    check_val("ack_rearm", cfg_ack, 1);
    cfg_valid = 1'b0;
    cyc(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
